// File: rtl/computie_bus_pkg.sv
// computie_bus_pkg: shared state encoding, trigger modes and record field offsets
// for the Computie bus-trace capture path.
package computie_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_HOLD,
        ST_DUMP
    } state_t;

    localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
    localparam logic [1:0] TRIG_ANY       = 2'd1;
    localparam logic [1:0] TRIG_READ      = 2'd2;
    localparam logic [1:0] TRIG_WRITE     = 2'd3;

    // A record is {modifier, addr, data}; the lowest modifier bit is the read flag.
    function automatic int RW_BIT(input int bw);
        return 2 * bw;
    endfunction

    function automatic int ADDR_HI(input int bw);
        return 2 * bw - 1;
    endfunction

    function automatic int ADDR_LO(input int bw);
        return bw;
    endfunction

    function automatic int DATA_HI(input int bw);
        return bw - 1;
    endfunction

    function automatic int DATA_LO(input int bw);
        return 0 * bw;
    endfunction

endpackage

// File: rtl/computie_bus_trigger_match.sv
// computie_bus_trigger_match: combinational address/direction comparator used
// to decide whether a snooped record fires the trace trigger.
module computie_bus_trigger_match
    import computie_bus_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int MODWIDTH = 1,
    localparam int W = BITWIDTH * 2 + MODWIDTH
) (
    input  logic [W-1:0]        rec_data,
    input  logic [BITWIDTH-1:0] trig_addr,
    input  logic [BITWIDTH-1:0] trig_mask,
    input  logic [1:0]          trig_mode,
    output logic                match
);

    localparam int RW = RW_BIT(BITWIDTH);
    localparam int AH = ADDR_HI(BITWIDTH);
    localparam int AL = ADDR_LO(BITWIDTH);

    logic addr_hit;
    logic dir_hit;
    logic rd;
    logic unused_rec;

    assign rd       = rec_data[RW];
    assign addr_hit = ((rec_data[AH:AL] ^ trig_addr) & trig_mask) == '0;
    assign dir_hit  = (trig_mode == TRIG_READ)  ? rd :
                      (trig_mode == TRIG_WRITE) ? !rd : 1'b1;
    assign match    = (trig_mode == TRIG_IMMEDIATE) || (addr_hit && dir_hit);
    assign unused_rec = ^rec_data;

endmodule

// File: rtl/computie_bus_trace_controller.sv
// computie_bus_trace_controller: arms, waits for a trigger, captures a fixed
// number of snooped bus records into the FIFO and hands it to the dumper.
module computie_bus_trace_controller
    import computie_bus_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int MODWIDTH = 1,
    parameter int DEPTH    = 512,
    localparam int W  = BITWIDTH * 2 + MODWIDTH,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                comm_clock,
    input  logic                reset,
    input  logic                arm,
    input  logic                abort,
    input  logic                auto_dump,
    input  logic                dump_req,
    input  logic [1:0]          trig_mode,
    input  logic [BITWIDTH-1:0] trig_addr,
    input  logic [BITWIDTH-1:0] trig_mask,
    input  logic [CW-1:0]       capture_len,
    input  logic                rec_valid,
    input  logic [W-1:0]        rec_data,
    output logic                fifo_wr,
    output logic [W-1:0]        fifo_wr_data,
    input  logic                fifo_full,
    input  logic                fifo_empty,
    output logic                dump_start,
    input  logic                dump_end,
    output logic                busy,
    output logic                triggered,
    output logic                overflow,
    output logic [CW-1:0]       captured
);

    state_t        state, state_next, done_state;
    logic          match;
    logic          done;
    logic          wr_next;
    logic          start_next;
    logic          trig_set;
    logic          ovf_set;
    logic          clear;
    logic [CW-1:0] eff_len;

    computie_bus_trigger_match #(
        .BITWIDTH (BITWIDTH),
        .MODWIDTH (MODWIDTH)
    ) u_match (
        .rec_data  (rec_data),
        .trig_addr (trig_addr),
        .trig_mask (trig_mask),
        .trig_mode (trig_mode),
        .match     (match)
    );

    assign eff_len = (capture_len == '0 || capture_len > CW'(DEPTH)) ? CW'(DEPTH) : capture_len;
    // Completion is judged one cycle after the last write so the dumper sees that write first.
    assign done       = (captured >= eff_len) || overflow;
    assign done_state = fifo_empty ? ST_IDLE : (auto_dump ? ST_DUMP : ST_HOLD);

    always_ff @(posedge comm_clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        wr_next    = 1'b0;
        start_next = 1'b0;
        trig_set   = 1'b0;
        ovf_set    = 1'b0;
        clear      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arm && !abort) begin
                    state_next = ST_ARMED;
                    clear      = 1'b1;
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (rec_valid && match) begin
                    state_next = ST_CAPTURE;
                    trig_set   = 1'b1;
                    wr_next    = !fifo_full;
                    ovf_set    = fifo_full;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (done) begin
                    state_next = done_state;
                    start_next = done_state == ST_DUMP;
                end else if (rec_valid) begin
                    wr_next = !fifo_full;
                    ovf_set = fifo_full;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (dump_req) begin
                    state_next = ST_DUMP;
                    start_next = 1'b1;
                end
            end
            ST_DUMP: begin
                if (dump_end) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge comm_clock) begin
        if (reset) begin
            fifo_wr      <= 1'b0;
            fifo_wr_data <= '0;
            dump_start   <= 1'b0;
            busy         <= 1'b0;
            triggered    <= 1'b0;
            overflow     <= 1'b0;
            captured     <= '0;
        end else begin
            fifo_wr    <= wr_next;
            dump_start <= start_next;
            busy       <= state_next != ST_IDLE;
            triggered  <= !clear && (triggered || trig_set);
            overflow   <= !clear && (overflow || ovf_set);
            captured   <= clear ? '0 : captured + CW'(wr_next);
            if (wr_next) fifo_wr_data <= rec_data;
        end
    end

endmodule

// File: tb/tb_computie_bus_trace_controller.sv
// tb_computie_bus_trace_controller: directed stimulus with a scoreboard of
// expected FIFO writes and dump_start pulses checked by a separate monitor.
module tb_computie_bus_trace_controller;

    localparam int BW = 32;
    localparam int W  = 65;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          arm = 1'b0, abort = 1'b0, auto_dump = 1'b0, dump_req = 1'b0;
    logic [1:0]    trig_mode = 2'd0;
    logic [BW-1:0] trig_addr = '0, trig_mask = '0;
    logic [CW-1:0] capture_len = '0;
    logic          rec_valid = 1'b0;
    logic [W-1:0]  rec_data = '0;
    logic          fifo_full = 1'b0, fifo_empty = 1'b0, dump_end = 1'b0;
    logic          fifo_wr, dump_start, busy, triggered, overflow;
    logic [W-1:0]  fifo_wr_data;
    logic [CW-1:0] captured;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_wr_cyc = -100;

    logic [W-1:0]  exp_data[$];
    logic [CW-1:0] exp_cap[$];
    int            exp_dcap[$];
    int            exp_dgap[$];

    computie_bus_trace_controller dut (
        .comm_clock   (clk),
        .reset        (reset),
        .arm          (arm),
        .abort        (abort),
        .auto_dump    (auto_dump),
        .dump_req     (dump_req),
        .trig_mode    (trig_mode),
        .trig_addr    (trig_addr),
        .trig_mask    (trig_mask),
        .capture_len  (capture_len),
        .rec_valid    (rec_valid),
        .rec_data     (rec_data),
        .fifo_wr      (fifo_wr),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .dump_start   (dump_start),
        .dump_end     (dump_end),
        .busy         (busy),
        .triggered    (triggered),
        .overflow     (overflow),
        .captured     (captured)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rec(input logic rw, input logic [BW-1:0] a, input logic [BW-1:0] d);
        return {rw, a, d};
    endfunction

    task automatic send(input logic [W-1:0] r, input bit expect_wr, input int cap);
        rec_valid = 1'b1;
        rec_data  = r;
        if (expect_wr) begin
            exp_data.push_back(r);
            exp_cap.push_back(CW'(cap));
        end
        tick();
    endtask

    task automatic end_dump();
        dump_end = 1'b1;
        tick();
        dump_end = 1'b0;
        chk("busy_after_dump_end", W'(busy), W'(0));
    endtask

    // Monitor: every FIFO write and dump_start pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        cyc++;
        if (fifo_wr === 1'b1) begin
            if (exp_data.size() == 0) begin
                chk("unexpected_fifo_wr", W'(fifo_wr), W'(0));
            end else begin
                chk("fifo_wr_data", fifo_wr_data, exp_data.pop_front());
                chk("captured_at_wr", W'(captured), W'(exp_cap.pop_front()));
            end
            last_wr_cyc = cyc;
        end
        if (dump_start === 1'b1) begin
            if (exp_dcap.size() == 0) begin
                chk("unexpected_dump_start", W'(dump_start), W'(0));
            end else begin
                int g;
                chk("captured_at_dump", W'(captured), W'(exp_dcap.pop_front()));
                g = exp_dgap.pop_front();
                if (g >= 0) chk("dump_start_gap", W'(cyc - last_wr_cyc), W'(g));
            end
        end
    end

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_fifo_wr", W'(fifo_wr), W'(0));
        chk("rst_wr_data", fifo_wr_data, W'(0));
        chk("rst_dump_start", W'(dump_start), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_triggered", W'(triggered), W'(0));
        chk("rst_overflow", W'(overflow), W'(0));
        chk("rst_captured", W'(captured), W'(0));

        // Immediate mode: 6 records offered, 4 captured, auto dump.
        trig_mode = 2'd0; capture_len = 10'd4; auto_dump = 1'b1;
        arm = 1'b1; tick(); arm = 1'b0;
        chk("imm_busy_armed", W'(busy), W'(1));
        exp_dcap.push_back(4); exp_dgap.push_back(1);
        for (int i = 0; i < 6; i++)
            send(rec(i[0], 32'h1000 + i, 32'h30 * i), i < 4, i + 1);
        rec_valid = 1'b0;
        tick();
        chk("imm_busy_dump", W'(busy), W'(1));
        chk("imm_triggered", W'(triggered), W'(1));
        chk("imm_captured", W'(captured), W'(4));
        end_dump();
        chk("imm_captured_kept", W'(captured), W'(4));

        // Masked write trigger: read and off-mask write must not fire.
        trig_mode = 2'd3; trig_addr = 32'h00FF0010; trig_mask = 32'hFFFFFFF0; capture_len = 10'd2;
        arm = 1'b1; tick(); arm = 1'b0;
        chk("mask_cleared_cap", W'(captured), W'(0));
        send(rec(1'b1, 32'h00FF0014, 32'hAAAA), 0, 0);
        send(rec(1'b0, 32'h00FF0024, 32'hDDDD), 0, 0);
        rec_valid = 1'b0; tick();
        chk("mask_not_triggered", W'(triggered), W'(0));
        chk("mask_busy_armed", W'(busy), W'(1));
        exp_dcap.push_back(2); exp_dgap.push_back(1);
        send(rec(1'b0, 32'h00FF001C, 32'hBBBB), 1, 1);
        chk("mask_triggered", W'(triggered), W'(1));
        send(rec(1'b1, 32'h12345678, 32'hCCCC), 1, 2);
        rec_valid = 1'b0; tick(); tick();
        end_dump();

        // FIFO full mid-capture forces completion with overflow.
        trig_mode = 2'd0; capture_len = 10'd8;
        arm = 1'b1; tick(); arm = 1'b0;
        exp_dcap.push_back(3); exp_dgap.push_back(-1);
        for (int i = 0; i < 3; i++)
            send(rec(1'b0, 32'h2000 + i, 32'h5 + i), 1, i + 1);
        fifo_full = 1'b1;
        send(rec(1'b0, 32'h2003, 32'h8), 0, 0);
        rec_valid = 1'b0; tick();
        chk("full_overflow", W'(overflow), W'(1));
        chk("full_captured", W'(captured), W'(3));
        chk("full_busy", W'(busy), W'(1));
        tick();
        fifo_full = 1'b0;
        end_dump();

        // HOLD, manual dump, abort ignored in DUMP.
        auto_dump = 1'b0; capture_len = 10'd2;
        arm = 1'b1; tick(); arm = 1'b0;
        send(rec(1'b1, 32'h3000, 32'h1), 1, 1);
        send(rec(1'b0, 32'h3004, 32'h2), 1, 2);
        rec_valid = 1'b0; tick(); tick(); tick();
        chk("hold_busy", W'(busy), W'(1));
        exp_dcap.push_back(2); exp_dgap.push_back(-1);
        dump_req = 1'b1; tick(); dump_req = 1'b0;
        chk("hold_dump_start", W'(dump_start), W'(1));
        abort = 1'b1; tick(); abort = 1'b0;
        chk("dump_abort_busy", W'(busy), W'(1));
        tick();
        chk("dump_start_one_cycle", W'(dump_start), W'(0));
        end_dump();

        // arm with abort in IDLE, stray dump_end in IDLE.
        arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
        chk("arm_abort_idle", W'(busy), W'(0));
        dump_end = 1'b1; tick(); dump_end = 1'b0;
        chk("stray_end_idle", W'(busy), W'(0));

        // capture_len 1 with an empty FIFO at completion returns to IDLE without dumping.
        auto_dump = 1'b1; capture_len = 10'd1; fifo_empty = 1'b1;
        arm = 1'b1; tick(); arm = 1'b0;
        send(rec(1'b0, 32'h4000, 32'h77), 1, 1);
        rec_valid = 1'b0; tick();
        chk("empty_skip_idle", W'(busy), W'(0));
        chk("empty_captured", W'(captured), W'(1));
        fifo_empty = 1'b0;

        // Reset mid-capture.
        capture_len = 10'd8;
        arm = 1'b1; tick(); arm = 1'b0;
        send(rec(1'b0, 32'h5000, 32'h9), 1, 1);
        send(rec(1'b0, 32'h5004, 32'hA), 1, 2);
        reset = 1'b1;
        send(rec(1'b0, 32'h5008, 32'hB), 0, 0);
        reset = 1'b0; rec_valid = 1'b0;
        chk("mid_rst_fifo_wr", W'(fifo_wr), W'(0));
        chk("mid_rst_wr_data", fifo_wr_data, W'(0));
        chk("mid_rst_busy", W'(busy), W'(0));
        chk("mid_rst_triggered", W'(triggered), W'(0));
        chk("mid_rst_captured", W'(captured), W'(0));
        dump_end = 1'b1; tick(); dump_end = 1'b0;
        chk("post_rst_end_busy", W'(busy), W'(0));

        tick(); tick();
        chk("wr_queue_drained", W'(exp_data.size()), W'(0));
        chk("dump_queue_drained", W'(exp_dcap.size()), W'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
